// File: rtl/ldpc_pkg.sv
// ldpc_pkg: frame-size helpers and frame-buffer occupancy encoding shared
// by the LDPC loader, decoder and check blocks.
package ldpc_pkg;

  // Number of full banks held by a ping-pong frame buffer
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // Frame size in bits: R block rows of D-bit circulants
  function automatic int frame_bits(input int r, input int d);
    return r * d;
  endfunction

  // Input beats per frame
  function automatic int frame_beats(input int r, input int d, input int in_w);
    return (r * d) / in_w;
  endfunction

  // Beat counter width; never narrower than one bit
  function automatic int cnt_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/ldpc_frame_bank.sv
// ldpc_frame_bank: one N-bit frame register, written one IN_W slice at a
// time (slice wr_idx covers bits [wr_idx*IN_W +: IN_W]), cleared by reset.
module ldpc_frame_bank
  import ldpc_pkg::*;
#(
  parameter int N    = 64,
  parameter int IN_W = 8,
  parameter int BW   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [BW-1:0]   wr_idx,
  input  logic [IN_W-1:0] wr_data,
  output logic [N-1:0]    q
);

  logic [N-1:0] r_q;

  // Slice write; untouched slices keep their value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_q <= '0;
    else if (wr_en) r_q[wr_idx*IN_W +: IN_W] <= wr_data;
  end

  assign q = r_q;

endmodule

// File: rtl/ldpc_frame_loader.sv
// ldpc_frame_loader: assembles IN_W-bit beats into R*D-bit frames in two
// ping-pong banks and hands them to the decoder over valid/ready.
// Optional build macro LDPC_LOADER_LEN_CHECK_EN: drop frames whose in_last
// marker disagrees with the beat count and pulse len_err.
module ldpc_frame_loader
  import ldpc_pkg::*;
#(
  parameter int R    = 8,
  parameter int D    = 8,
  parameter int IN_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [R*D-1:0]    frm_data,
  output logic              frm_valid,
  input  logic              frm_ready,
  output logic              len_err
);

  localparam int N     = frame_bits(R, D);
  localparam int BEATS = frame_beats(R, D, IN_W);
  localparam int BW    = cnt_w(BEATS);
  localparam logic [BW-1:0] LAST_IDX = BW'(BEATS - 1);

  if ((R * D) % IN_W != 0) begin : g_bad_cfg
    $error("ldpc_frame_loader: R*D must be a multiple of IN_W");
  end

  occ_e          r_occ;
  logic          r_wbank;
  logic          r_rbank;
  logic [BW-1:0] r_beat_cnt;

  logic          w_acc;
  logic          w_last_beat;
  logic          w_commit;
  logic          w_drop;
  logic          w_pop;
  logic [1:0][N-1:0] w_bank_q;

  // Handshake decodes come from registered occupancy only
  assign in_ready    = (r_occ != OCC_TWO);
  assign frm_valid   = (r_occ != OCC_EMPTY);
  assign frm_data    = w_bank_q[r_rbank];
  assign w_acc       = in_valid & in_ready;
  assign w_pop       = frm_valid & frm_ready;
  assign w_last_beat = (r_beat_cnt == LAST_IDX);

`ifdef LDPC_LOADER_LEN_CHECK_EN
  logic r_len_err;

  // in_last must coincide exactly with the final beat of the count
  assign w_commit = w_acc & w_last_beat & in_last;
  assign w_drop   = w_acc & (w_last_beat ^ in_last);
  assign len_err  = r_len_err;

  // One-cycle pulse the clock after a malformed frame is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_len_err <= 1'b0;
    else        r_len_err <= w_drop;
  end
`else
  logic w_unused_last;

  // Frames delimited purely by beat count
  assign w_commit      = w_acc & w_last_beat;
  assign w_drop        = 1'b0;
  assign len_err       = 1'b0;
  assign w_unused_last = in_last;
`endif

  // Beat counter and bank pointers; a dropped frame restarts at slice 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_cnt <= '0;
      r_wbank    <= 1'b0;
      r_rbank    <= 1'b0;
    end else begin
      if (w_acc)    r_beat_cnt <= (w_commit | w_drop) ? '0 : r_beat_cnt + 1'b1;
      if (w_commit) r_wbank    <= ~r_wbank;
      if (w_pop)    r_rbank    <= ~r_rbank;
    end
  end

  // Occupancy FSM; commit and pop in the same cycle cancel out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_occ <= OCC_EMPTY;
    else begin
      case (r_occ)
        OCC_EMPTY: if (w_commit) r_occ <= OCC_ONE;
        OCC_ONE: begin
          if (w_commit && !w_pop)      r_occ <= OCC_TWO;
          else if (!w_commit && w_pop) r_occ <= OCC_EMPTY;
        end
        OCC_TWO:   if (w_pop) r_occ <= OCC_ONE;
        default:   r_occ <= OCC_EMPTY;
      endcase
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    ldpc_frame_bank #(.N(N), .IN_W(IN_W), .BW(BW)) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (w_acc & (r_wbank == 1'(g))),
      .wr_idx  (r_beat_cnt),
      .wr_data (in_data),
      .q       (w_bank_q[g])
    );
  end

endmodule

// File: tb/tb_ldpc_frame_loader.sv
// Bench for ldpc_frame_loader (R=D=IN_W=8): reset table, ordering,
// commit+pop, length check (LDPC_LOADER_LEN_CHECK_EN aware), reset abort,
// and a randomized scoreboard run.
module tb_ldpc_frame_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [63:0] frm_data;
  logic        frm_valid;
  logic        frm_ready;
  logic        len_err;

  int checks   = 0;
  int failures = 0;

  ldpc_frame_loader #(.R(8), .D(8), .IN_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .frm_data  (frm_data),
    .frm_valid (frm_valid),
    .frm_ready (frm_ready),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  d;
    logic        v, l, fr;
    logic        e_rdy, e_fv, e_le;
    logic [63:0] e_data;
  } vec_t;

  vec_t        tv[10];
  logic [63:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [7:0] base);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[b*8 +: 8] = base + 8'(b);
    return r;
  endfunction

  // Called at a negedge; returns at the negedge after the beat is accepted
  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    in_data = d; in_valid = 1'b1; in_last = l;
    while (!in_ready && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=stalled required=accept");
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    logic [63:0] acc;
    logic [63:0] hold, fr;
    logic        have_hold;
    int          rx, cyc;

    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; frm_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_frm_valid", frm_valid, 0);
    chk("rst_frm_data", frm_data, 0);
    chk("rst_len_err", len_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- test 1: table-driven single frame, bytes 01..08 ----
    acc = '0;
    for (int k = 0; k < 8; k++) begin
      tv[k].d = 8'(k + 1); tv[k].v = 1'b1; tv[k].l = (k == 7); tv[k].fr = 1'b1;
      tv[k].e_rdy = 1'b1; tv[k].e_fv = 1'b0; tv[k].e_le = 1'b0; tv[k].e_data = acc;
      acc[k*8 +: 8] = 8'(k + 1);
    end
    tv[8].d = '0; tv[8].v = 1'b0; tv[8].l = 1'b0; tv[8].fr = 1'b1;
    tv[8].e_rdy = 1'b1; tv[8].e_fv = 1'b1; tv[8].e_le = 1'b0; tv[8].e_data = 64'h0807060504030201;
    tv[9].d = '0; tv[9].v = 1'b0; tv[9].l = 1'b0; tv[9].fr = 1'b0;
    tv[9].e_rdy = 1'b1; tv[9].e_fv = 1'b0; tv[9].e_le = 1'b0; tv[9].e_data = '0;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t1_rdy_%0d", i), in_ready, tv[i].e_rdy);
      chk($sformatf("t1_fv_%0d", i), frm_valid, tv[i].e_fv);
      chk($sformatf("t1_le_%0d", i), len_err, tv[i].e_le);
      chk($sformatf("t1_data_%0d", i), frm_data, tv[i].e_data);
      in_data = tv[i].d; in_valid = tv[i].v; in_last = tv[i].l; frm_ready = tv[i].fr;
      @(negedge clk);
    end
    in_valid = 1'b0; frm_ready = 1'b0;

    // ---- test 2: A,B,C back to back under backpressure ----
    for (int b = 0; b < 8; b++) send(8'hA0 + 8'(b), b == 7);
    chk("t2_a_valid", frm_valid, 1);
    chk("t2_a_data", frm_data, mk(8'hA0));
    for (int b = 0; b < 8; b++) send(8'hB0 + 8'(b), b == 7);
    chk("t2_full_rdy", in_ready, 0);
    chk("t2_full_data", frm_data, mk(8'hA0));
    in_data = 8'hC0; in_valid = 1'b1; in_last = 1'b0;
    @(negedge clk);
    chk("t2_stall_rdy", in_ready, 0);
    chk("t2_stall_data", frm_data, mk(8'hA0));
    frm_ready = 1'b1;
    chk("t2_pop_cycle_rdy", in_ready, 0);
    @(negedge clk);
    frm_ready = 1'b0;
    chk("t2_after_pop_rdy", in_ready, 1);
    chk("t2_b_data", frm_data, mk(8'hB0));
    @(negedge clk);
    in_valid = 1'b0;
    for (int b = 1; b < 8; b++) send(8'hC0 + 8'(b), b == 7);
    chk("t2_b_held", frm_data, mk(8'hB0));
    chk("t2_two_rdy", in_ready, 0);
    frm_ready = 1'b1;
    @(negedge clk);
    chk("t2_c_valid", frm_valid, 1);
    chk("t2_c_data", frm_data, mk(8'hC0));
    @(negedge clk);
    frm_ready = 1'b0;
    chk("t2_drained", frm_valid, 0);

    // ---- test 3: final beat of B with pop of A in the same cycle ----
    for (int b = 0; b < 8; b++) send(8'h30 + 8'(b), b == 7);
    for (int b = 0; b < 7; b++) send(8'h40 + 8'(b), 1'b0);
    chk("t3_a_data", frm_data, mk(8'h30));
    in_data = 8'h47; in_valid = 1'b1; in_last = 1'b1; frm_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; frm_ready = 1'b0;
    chk("t3_valid", frm_valid, 1);
    chk("t3_b_data", frm_data, mk(8'h40));
    chk("t3_occ_one_rdy", in_ready, 1);
    frm_ready = 1'b1;
    @(negedge clk);
    frm_ready = 1'b0;
    chk("t3_drained", frm_valid, 0);

    // ---- test 4: short frame (in_last on beat 5) ----
    for (int b = 0; b < 5; b++) send(8'hD0 + 8'(b), b == 4);
`ifdef LDPC_LOADER_LEN_CHECK_EN
    chk("t4_len_err", len_err, 1);
    chk("t4_no_valid", frm_valid, 0);
    @(negedge clk);
    chk("t4_len_err_pulse", len_err, 0);
    for (int b = 0; b < 8; b++) send(8'hE0 + 8'(b), b == 7);
    chk("t4_next_valid", frm_valid, 1);
    chk("t4_next_data", frm_data, mk(8'hE0));
    chk("t4_next_le", len_err, 0);
    frm_ready = 1'b1; @(negedge clk); frm_ready = 1'b0;
    for (int b = 0; b < 8; b++) send(8'h50 + 8'(b), 1'b0);
    chk("t4_nolast_err", len_err, 1);
    chk("t4_nolast_valid", frm_valid, 0);
    @(negedge clk);
    chk("t4_nolast_pulse", len_err, 0);
`else
    chk("t4_no_len_err", len_err, 0);
    chk("t4_no_valid", frm_valid, 0);
    for (int b = 0; b < 3; b++) send(8'hE0 + 8'(b), b == 2);
    chk("t4_valid", frm_valid, 1);
    chk("t4_data", frm_data, 64'hE2E1E0D4D3D2D1D0);
    chk("t4_le", len_err, 0);
    frm_ready = 1'b1; @(negedge clk); frm_ready = 1'b0;
`endif
    chk("t4_drained", frm_valid, 0);

    // ---- test 5: reset mid-frame with a frame held ----
    for (int b = 0; b < 8; b++) send(8'h60 + 8'(b), b == 7);
    for (int b = 0; b < 4; b++) send(8'h70 + 8'(b), 1'b0);
    chk("t5_pre_valid", frm_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_rdy", in_ready, 1);
    chk("t5_rst_fv", frm_valid, 0);
    chk("t5_rst_data", frm_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int b = 0; b < 8; b++) send(8'h80 + 8'(b), b == 7);
    chk("t5_new_data", frm_data, mk(8'h80));
    frm_ready = 1'b1; @(negedge clk); frm_ready = 1'b0;
    chk("t5_drained", frm_valid, 0);

    // ---- test 6: random gaps and backpressure, 1000 frames ----
    rx = 0; cyc = 0; have_hold = 1'b0;
    fork
      begin
        for (int f = 0; f < 1000; f++) begin
          for (int b = 0; b < 8; b++) fr[b*8 +: 8] = 8'($urandom_range(0, 255));
          for (int b = 0; b < 8; b++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            if (b == 7) exp_q.push_back(fr);
            send(fr[b*8 +: 8], b == 7);
          end
        end
      end
      begin
        while (rx < 1000 && cyc < 60000) begin
          @(negedge clk);
          cyc++;
          if (have_hold) begin
            chk("t6_stable_valid", frm_valid, 1);
            chk("t6_stable_data", frm_data, hold);
          end
          frm_ready = ($urandom_range(0, 9) < 6);
          have_hold = frm_valid & ~frm_ready;
          hold = frm_data;
          if (frm_valid && frm_ready) begin
            if (exp_q.size() == 0) chk("t6_unexpected_frame", frm_data, 64'hx);
            else chk($sformatf("t6_frame_%0d", rx), frm_data, exp_q.pop_front());
            rx++;
          end
        end
        @(negedge clk);
        frm_ready = 1'b0;
      end
    join
    chk("t6_frames_rx", 64'(rx), 64'd1000);
    chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
